// File: rtl/terminal_reader_pkg.sv
// terminal_pkg: shared terminal grid geometry, ASCII codes and reader state type
package terminal_pkg;
  localparam int TERM_WIDTH = 76;
  localparam int TERM_HEIGHT = 44;
  localparam int TERM_STATUS_ROW = 42;
  localparam logic [7:0] ASCII_NL = 8'd10;
  localparam logic [7:0] ASCII_SPACE = 8'd32;
  localparam logic [7:0] ASCII_EOT = 8'h04;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, EMIT, EOT, DONE} tr_state_t;
endpackage

// File: rtl/terminal_reader_if.sv
// terminal_reader_if: ASCII byte stream; master = reader (char_out, char_valid_out), slave = consumer (char_ready_in)
interface terminal_reader_if;
  logic [7:0] char_out;
  logic char_valid_out;
  logic char_ready_in;
  modport master(output char_out, char_valid_out, input char_ready_in);
  modport slave(input char_out, char_valid_out, output char_ready_in);
endinterface

// File: rtl/terminal_reader.sv
// terminal_reader: scans the text grid row-major and streams its bytes, then EOT
// Ports: pixel_clk_in/rst_in clock and sync reset; start_in begins a scan;
// tg_addr/tg_data grid read port; bus byte stream; busy_out scan active; done_out end pulse
module terminal_reader
  import terminal_pkg::*;
#(
  parameter int SCREEN_WIDTH = TERM_WIDTH,
  parameter int SCREEN_HEIGHT = TERM_HEIGHT,
  parameter int STATUS_ROW = TERM_STATUS_ROW,
  parameter int READ_LATENCY = 2,
  localparam int AW = $clog2(SCREEN_WIDTH * SCREEN_HEIGHT)
) (
  input  logic pixel_clk_in,
  input  logic rst_in,
  input  logic start_in,
  output logic [AW-1:0] tg_addr,
  input  logic [7:0] tg_data,
  terminal_reader_if.master bus,
  output logic busy_out,
  output logic done_out
);
  localparam int XW = $clog2(SCREEN_WIDTH + 1);
  localparam int YW = $clog2(SCREEN_HEIGHT + 2);
  localparam int CW = $clog2(READ_LATENCY + 1);
  localparam logic [YW-1:0] Y0 = YW'(STATUS_ROW == 0 ? 1 : 0);
  tr_state_t state;
  logic [XW-1:0] x, nx;
  logic [YW-1:0] y, ny1, ny, nyy;
  logic [CW-1:0] cnt;
  logic nl, last;
  function automatic logic [AW-1:0] addr_of(input logic [YW-1:0] yy, input logic [XW-1:0] xx);
    return AW'(yy) * AW'(SCREEN_WIDTH) + AW'(xx);
  endfunction
  // next cell after the byte in char_out is accepted; a newline or row end skips to the next row
  always_comb begin
    nl = bus.char_out == ASCII_NL || x == XW'(SCREEN_WIDTH - 1);
    ny1 = y + YW'(1);
    ny = ny1 + YW'(ny1 == YW'(STATUS_ROW));
    nx = nl ? '0 : x + XW'(1);
    nyy = nl ? ny : y;
    last = nyy >= YW'(SCREEN_HEIGHT);
  end
  // tg_addr is loaded when entering ISSUE so the read is in flight from the ISSUE cycle;
  // the byte is then captured as the counter steps 1 -> 0, giving READ_LATENCY+2 cycles per byte
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      state <= IDLE;
      x <= '0;
      y <= '0;
      cnt <= '0;
      tg_addr <= '0;
      bus.char_out <= '0;
      bus.char_valid_out <= 1'b0;
      busy_out <= 1'b0;
      done_out <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start_in) begin
          x <= '0;
          y <= Y0;
          tg_addr <= addr_of(Y0, '0);
          busy_out <= 1'b1;
          state <= ISSUE;
        end
        ISSUE: begin
          tg_addr <= addr_of(y, x);
          cnt <= CW'(READ_LATENCY);
          state <= WAIT;
        end
        WAIT: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            bus.char_out <= tg_data;
            bus.char_valid_out <= 1'b1;
            state <= EMIT;
          end
        end
        EMIT: if (bus.char_ready_in) begin
          bus.char_valid_out <= 1'b0;
          x <= nx;
          y <= nyy;
          tg_addr <= last ? tg_addr : addr_of(nyy, nx);
          state <= last ? EOT : ISSUE;
        end
        EOT: if (!bus.char_valid_out) begin
          bus.char_out <= ASCII_EOT;
          bus.char_valid_out <= 1'b1;
        end else if (bus.char_ready_in) begin
          bus.char_valid_out <= 1'b0;
          done_out <= 1'b1;
          busy_out <= 1'b0;
          state <= DONE;
        end
        DONE: begin
          done_out <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
